tv80_busrq_dma_ctrl: RTL
========================

// Module: tv80_busrq_dma_ctrl
// PURPOSE
//  Bus-master controller that borrows the tv80s memory bus via busrq_n/busak_n and performs a
//  memory-to-memory block copy on the shared 64K memory. Sits between a host/loader command
//  port and the CPU bus; the top level muxes A/dout/mreq_n/rd_n/wr_n onto the memory when bus_oe=1.
//  Releases the bus and returns control to the CPU once the copy completes or aborts.
// PARAMETERS
//  AW          16   address width (wraps modulo 2**AW)
//  DW          8    data width
//  LW          16   length counter width; max copy = 2**LW-1 bytes
//  ACK_TO      255  cycles to wait for busak_n=0 before abort; 0 = wait forever
// PORTS
//  clk          in   1   single system clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high reset
//  req_valid    in   1   copy command valid
//  req_ready    out  1   high only in IDLE; command accepted when req_valid&&req_ready
//  req_src      in   AW  source start address
//  req_dst      in   AW  destination start address
//  req_len      in   LW  byte count
//  busy         out  1   high from accept until the cycle done/err pulses
//  done         out  1   1-cycle pulse: copy finished, bus released
//  err          out  1   1-cycle pulse: busak timeout, nothing written
//  busrq_n      out  1   bus request to CPU, active low
//  busak_n      in   1   bus acknowledge from CPU, active low
//  bus_oe       out  1   controller owns bus; top-level mux select
//  A            out  AW  bus address
//  dout         out  DW  write data
//  di           in   DW  read data from memory
//  mreq_n/rd_n/wr_n out 1 bus strobes, active low
// BEHAVIOUR
//  Reset: state=IDLE; busrq_n=1, bus_oe=0, mreq_n=rd_n=wr_n=1, A=0, dout=0, busy=0, done=0,
//   err=0, req_ready=1 after reset deasserts. Reset mid-copy aborts at that edge, no done/err.
//  Accept latches src/dst/len; later changes on req_* ignored until next IDLE.
//  len==0: IDLE->FIN, done pulses 1 cycle after accept; busrq_n never asserted.
//  FSM (all transitions registered):
//   IDLE  : req_ready=1; on accept -> REQ (len!=0) or FIN (len==0)
//   REQ   : busrq_n=0; busak_n==0 -> RDA; timeout counter hits ACK_TO -> ABT
//   RDA   : bus_oe=1, A=src, mreq_n=0, rd_n=0 -> RDD
//   RDD   : strobes held; dout<=di at end of cycle -> WR
//   WR    : A=dst, mreq_n=0, wr_n=0, dout valid; src++, dst++, len-- ;
//           len(after dec)==0 -> REL else -> RDA
//   REL   : bus_oe=0, strobes=1, busrq_n=1; busak_n==1 -> FIN
//   FIN   : done=1 for 1 cycle -> IDLE
//   ABT   : busrq_n=1, err=1 for 1 cycle -> IDLE
//  Throughput: 3 cycles/byte; total = 1(accept)+REQ wait+3*len+REL wait+1.
//  Addresses wrap FFFF->0000 independently for src and dst. Copy is ascending only; overlapping
//   dst>src ranges propagate data (defined behaviour, no hazard detection).
//  busak_n deasserting during RDA/RDD/WR is ignored (CPU must honour busrq_n); bus_oe never
//   asserts unless busak_n was sampled low in REQ.
//  Strobes never low with bus_oe=0; rd_n and wr_n never low together.
// STRUCTURE
//  Shared package tv80_bus_pkg: state enum (IDLE,REQ,RDA,RDD,WR,REL,FIN,ABT), AW/DW defaults,
//   bus strobe struct {mreq_n,rd_n,wr_n}.
//  One sub-module: tv80_busrq_sync_timeout (busak_n handshake wait + ACK_TO counter, ack/timeout out).
//  Datapath (src/dst/len counters, data latch) inline.
// TESTING (bench: tv80s + negedge memory model, top-level mux on bus_oe)
//  1 CPU running NOP loop; copy src=1000 dst=2000 len=4 (11 22 33 44) -> mem[2000..2003]=11 22 33 44,
//    done after 3*4 bus cycles + handshake, CPU resumes with PC advanced, regs intact.
//  2 len=0 -> done 1 cycle after accept, busrq_n stays 1 throughout, memory unchanged.
//  3 src=FFFE dst=0010 len=3 -> reads FFFE,FFFF,0000; mem[0010..0012] match; both pointers wrap.
//  4 busak_n tied 1, ACK_TO=8 -> err pulse 9 cycles after accept, no strobe ever low, busrq_n=1 after.
//  5 reset asserted in WR of byte 2 of len=5 -> next edge busrq_n=1, bus_oe=0, only byte 1 written.
//  6 req_valid held with new args during busy -> ignored; second command accepted only after done.

Source files
------------

// File: rtl/tv80_bus_pkg.sv
// Shared types for the tv80 bus-borrowing DMA block copier.
// Contents:
//   AW_DEF/DW_DEF/LW_DEF/ACK_TO_DEF : default address/data/length widths and busak_n timeout
//   state_e                         : controller states, in the order a copy walks through them
//   strobe_t                        : active-low memory strobe bundle {mreq_n, rd_n, wr_n}
//   busOwned()                      : true for the states in which the controller drives the bus
package tv80_bus_pkg;

  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 8;
  localparam int LW_DEF     = 16;
  localparam int ACK_TO_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RDA,
    ST_RDD,
    ST_WR,
    ST_REL,
    ST_FIN,
    ST_ABT
  } state_e;

  typedef struct packed {
    logic mreq_n;
    logic rd_n;
    logic wr_n;
  } strobe_t;

  localparam strobe_t STROBE_IDLE  = '{mreq_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1};
  localparam strobe_t STROBE_READ  = '{mreq_n: 1'b0, rd_n: 1'b0, wr_n: 1'b1};
  localparam strobe_t STROBE_WRITE = '{mreq_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0};

  // Only the three transfer states may put anything on the shared bus.
  function automatic logic busOwned(state_e s);
    return (s == ST_RDA) || (s == ST_RDD) || (s == ST_WR);
  endfunction

endpackage

// File: rtl/tv80_busrq_dma_ctrl_if.sv
// Command port plus CPU-bus signals of the DMA copier, bundled as one interface.
// Modports:
//   master : the controller (takes commands, requests the bus, drives A/dout/strobes)
//   slave  : the surroundings (host issuing commands, CPU answering busrq_n, memory returning di)
// Signals:
//   req_valid/req_ready/req_src/req_dst/req_len : copy command handshake
//   busy/done/err                               : copy status
//   busrq_n/busak_n                             : bus request / acknowledge, active low
//   bus_oe/A/dout/di/mreq_n/rd_n/wr_n           : borrowed memory bus
interface tv80_busrq_dma_ctrl_if import tv80_bus_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) ();

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_src;
  logic [AW-1:0] req_dst;
  logic [LW-1:0] req_len;
  logic          busy;
  logic          done;
  logic          err;
  logic          busrq_n;
  logic          busak_n;
  logic          bus_oe;
  logic [AW-1:0] A;
  logic [DW-1:0] dout;
  logic [DW-1:0] di;
  logic          mreq_n;
  logic          rd_n;
  logic          wr_n;

  modport master (
    input  req_valid, req_src, req_dst, req_len, busak_n, di,
    output req_ready, busy, done, err, busrq_n, bus_oe, A, dout, mreq_n, rd_n, wr_n
  );

  modport slave (
    output req_valid, req_src, req_dst, req_len, busak_n, di,
    input  req_ready, busy, done, err, busrq_n, bus_oe, A, dout, mreq_n, rd_n, wr_n
  );

endinterface

// File: rtl/tv80_busrq_sync_timeout.sv
// Waits for the CPU to acknowledge a bus request and gives up after ACK_TO cycles.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   wait_i      : high while the controller is asking for the bus
//   busak_n_i   : bus acknowledge from the CPU, active low
//   ack_o       : acknowledge seen this cycle while waiting
//   timeout_o   : ACK_TO-th consecutive unacknowledged wait cycle (never when ACK_TO == 0)
module tv80_busrq_sync_timeout #(
  parameter int ACK_TO = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_i,
  input  logic busak_n_i,
  output logic ack_o,
  output logic timeout_o
);

  localparam int CW = (ACK_TO > 2) ? $clog2(ACK_TO) : 1;
  localparam logic [CW-1:0] LIMIT = (ACK_TO > 0) ? CW'(ACK_TO - 1) : '0;

  logic [CW-1:0] waitCnt_q, waitCnt_d;

  assign ack_o     = wait_i && !busak_n_i;
  assign timeout_o = (ACK_TO != 0) && wait_i && busak_n_i && (waitCnt_q == LIMIT);

  // The counter holds the number of unacknowledged cycles already spent in the
  // current wait, so the timeout fires on the ACK_TO-th such cycle. It is
  // cleared whenever the wait ends so every request starts from a full budget.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!wait_i || !busak_n_i || timeout_o) begin
      waitCnt_d = '0;
    end else begin
      waitCnt_d = waitCnt_q + CW'(1);
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt_q <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end

endmodule

// File: rtl/tv80_busrq_dma_ctrl.sv
// Bus-master block copier for the tv80s memory bus. Takes a copy command,
// borrows the bus with busrq_n/busak_n, moves req_len bytes from req_src to
// req_dst in ascending order (3 cycles per byte), then hands the bus back.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : tv80_busrq_dma_ctrl_if.master -- command port, status, busrq_n/busak_n
//                and the borrowed memory bus (bus_oe selects it at the top level)
// Parameters: AW address width, DW data width, LW length width, ACK_TO busak_n
// timeout in cycles (0 waits forever).
module tv80_busrq_dma_ctrl import tv80_bus_pkg::*; #(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int LW     = LW_DEF,
  parameter int ACK_TO = ACK_TO_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  tv80_busrq_dma_ctrl_if.master bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] srcAddr_q, srcAddr_d;
  logic [AW-1:0] dstAddr_q, dstAddr_d;
  logic [LW-1:0] len_q, len_d;
  logic [DW-1:0] data_q, data_d;

  logic          waitAck;
  logic          ackSeen;
  logic          ackTimeout;

  strobe_t       strobe;
  logic          busOe;
  logic          busRq_n;
  logic [AW-1:0] addrOut;

  assign waitAck = (state_q == ST_REQ);

  tv80_busrq_sync_timeout #(
    .ACK_TO (ACK_TO)
  ) u_ackWait (
    .clk       (clk),
    .reset     (reset),
    .wait_i    (waitAck),
    .busak_n_i (bus.busak_n),
    .ack_o     (ackSeen),
    .timeout_o (ackTimeout)
  );

  // Next-state and datapath updates. Command fields are captured only in IDLE,
  // so req_* may change freely while a copy runs. The length counter is checked
  // for 1 in WR because that is the byte whose decrement empties it.
  always_comb begin
    state_d   = state_q;
    srcAddr_d = srcAddr_q;
    dstAddr_d = dstAddr_q;
    len_d     = len_q;
    data_d    = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          srcAddr_d = bus.req_src;
          dstAddr_d = bus.req_dst;
          len_d     = bus.req_len;
          state_d   = (bus.req_len == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        if (ackSeen) begin
          state_d = ST_RDA;
        end else if (ackTimeout) begin
          state_d = ST_ABT;
        end
      end
      ST_RDA: begin
        state_d = ST_RDD;
      end
      ST_RDD: begin
        data_d  = bus.di;
        state_d = ST_WR;
      end
      ST_WR: begin
        srcAddr_d = srcAddr_q + AW'(1);
        dstAddr_d = dstAddr_q + AW'(1);
        len_d     = len_q - LW'(1);
        state_d   = (len_q == LW'(1)) ? ST_REL : ST_RDA;
      end
      ST_REL: begin
        if (bus.busak_n) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN, ST_ABT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any copy in progress at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      srcAddr_q <= '0;
      dstAddr_q <= '0;
      len_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      srcAddr_q <= srcAddr_d;
      dstAddr_q <= dstAddr_d;
      len_q     <= len_d;
      data_q    <= data_d;
    end
  end

  // Bus outputs decode straight from the registered state. The strobes and
  // the address are only non-idle inside the owned states, so nothing toggles
  // on the shared bus while the CPU has it.
  always_comb begin
    strobe  = STROBE_IDLE;
    busOe   = busOwned(state_q);
    busRq_n = 1'b1;
    addrOut = '0;
    unique case (state_q)
      ST_REQ: begin
        busRq_n = 1'b0;
      end
      ST_RDA, ST_RDD: begin
        busRq_n = 1'b0;
        addrOut = srcAddr_q;
        strobe  = STROBE_READ;
      end
      ST_WR: begin
        busRq_n = 1'b0;
        addrOut = dstAddr_q;
        strobe  = STROBE_WRITE;
      end
      default: begin
        busRq_n = 1'b1;
      end
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_FIN);
  assign bus.err       = (state_q == ST_ABT);
  assign bus.busrq_n   = busRq_n;
  assign bus.bus_oe    = busOe;
  assign bus.A         = addrOut;
  assign bus.dout      = data_q;
  assign bus.mreq_n    = strobe.mreq_n;
  assign bus.rd_n      = strobe.rd_n;
  assign bus.wr_n      = strobe.wr_n;

endmodule
